// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory arbiter between CPU MEM stage and loader
// CPU has priority unless the loader has been refused STARVE cycles in a row; boot_i locks out the CPU.
module dmem_arbiter #(
   parameter int AW     = 14,
   parameter int DW     = 32,
   parameter int STARVE = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          boot_i,
   input  logic          c_req_i,
   input  logic          c_we_i,
   input  logic [AW-1:0] c_addr_i,
   input  logic [DW-1:0] c_wdata_i,
   output logic          c_gnt_o,
   output logic          c_stall_o,
   output logic          c_rvalid_o,
   output logic [DW-1:0] c_rdata_o,
   input  logic          l_req_i,
   input  logic          l_we_i,
   input  logic [AW-1:0] l_addr_i,
   input  logic [DW-1:0] l_wdata_i,
   output logic          l_gnt_o,
   output logic          l_rvalid_o,
   output logic [DW-1:0] l_rdata_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i
);

   localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_LDR  = 2'd2;

   logic [SW-1:0] starve_cnt_q, starve_cnt_d;
   logic [1:0]    owner_q, owner_d;
   logic          c_win, l_win;

   always_comb begin
      c_win = 1'b0;
      l_win = 1'b0;
      if (rst_n) begin
         if (boot_i) begin
            l_win = l_req_i;
         end else if (c_req_i && l_req_i) begin
            if (starve_cnt_q == STARVE_MAX) l_win = 1'b1;
            else                            c_win = 1'b1;
         end else begin
            c_win = c_req_i;
            l_win = l_req_i;
         end
      end
   end

   always_comb begin
      mem_en_o    = c_win | l_win;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (c_win) begin
         mem_we_o    = c_we_i;
         mem_addr_o  = c_addr_i;
         mem_wdata_o = c_wdata_i;
      end else if (l_win) begin
         mem_we_o    = l_we_i;
         mem_addr_o  = l_addr_i;
         mem_wdata_o = l_wdata_i;
      end
   end

   always_comb begin
      starve_cnt_d = '0;
      if (l_req_i && !l_win) begin
         starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
      end
      owner_d = OWN_NONE;
      if (c_win && !c_we_i)      owner_d = OWN_CPU;
      else if (l_win && !l_we_i) owner_d = OWN_LDR;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
         owner_q      <= OWN_NONE;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         owner_q      <= owner_d;
      end
   end

   // Read data is steered by the tag captured at grant time, so boot_i changes cannot misroute it.
   assign c_gnt_o    = c_win;
   assign l_gnt_o    = l_win;
   assign c_stall_o  = c_req_i & ~c_win;
   assign c_rvalid_o = (owner_q == OWN_CPU);
   assign l_rvalid_o = (owner_q == OWN_LDR);
   assign c_rdata_o  = (owner_q == OWN_CPU) ? mem_rdata_i : '0;
   assign l_rdata_o  = (owner_q == OWN_LDR) ? mem_rdata_i : '0;

endmodule
